ysyx_22050854_div_ctrl: RTL and testbench

- Multi-cycle radix-2 restoring divider with its sequencing FSM; replaces the single-cycle combinational div/rem path in the execute stage.
- Takes the same 4-bit mul/div control encoding the ALU uses for div/rem ops.
- Uses a valid/ready handshake on both sides so the pipeline can stall around it.
- Handles signed, unsigned and word (32-bit) forms, plus RISC-V divide-by-zero and overflow results.

---
 rtl/ysyx_22050854_div_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ysyx_22050854_div_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for the execute stage, with valid/ready on both sides.
// Handles signed/unsigned, 64-bit and word forms, including the divide-by-zero and overflow results.
//
// state | meaning
// IDLE  | waiting for a request, div_ready high
// CALC  | one quotient bit per cycle, W cycles
// FIX   | apply signs, select quotient/remainder, word sign-extension
// DONE  | result presented, waiting for out_ready
module ysyx_22050854_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [3:0]      div_ctr,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            is_rem;
    logic            is_word;

    logic            accept;
    logic            op_word;
    logic            op_rem;
    logic            op_uns;
    logic [XLEN-1:0] src1_ext;
    logic [XLEN-1:0] src2_ext;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] spec_q;
    logic [XLEN-1:0] spec_r;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // bit2 of the control field is don't-care
    logic unused_ctr;
    assign unused_ctr = div_ctr[2];

    function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    assign div_ready = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = div_valid & div_ready & ~flush;

    assign op_word = div_ctr[3];
    assign op_rem  = div_ctr[1];
    assign op_uns  = div_ctr[0];

    always_comb begin
        src1_ext = src1;
        src2_ext = src2;
        if (op_word) begin
            src1_ext = op_uns ? {{(XLEN-32){1'b0}}, src1[31:0]} : {{(XLEN-32){src1[31]}}, src1[31:0]};
            src2_ext = op_uns ? {{(XLEN-32){1'b0}}, src2[31:0]} : {{(XLEN-32){src2[31]}}, src2[31:0]};
        end
    end

    assign s1   = ~op_uns & src1_ext[XLEN-1];
    assign s2   = ~op_uns & src2_ext[XLEN-1];
    assign abs1 = s1 ? -src1_ext : src1_ext;
    assign abs2 = s2 ? -src2_ext : src2_ext;

    assign div_zero = op_word ? (src2[31:0] == 32'h0) : (src2 == '0);
    assign overflow = ~op_uns & (op_word
                    ? (src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF)
                    : (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1));
    assign special  = div_zero | overflow;

    assign spec_q = div_zero ? '1 : src1_ext;
    assign spec_r = div_zero ? src1_ext : '0;

    // Remainder is always below the divisor, so one extra bit holds the shifted trial value.
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs};

    assign quo_fix = q_neg ? -quo : quo;
    assign rem_fix = r_neg ? -rem : rem;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            is_rem  <= 1'b0;
            is_word <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            // Word dividends sit in the top half so the MSB-first shift sees bit 31 first.
            quo     <= op_word ? {abs1[31:0], {(XLEN-32){1'b0}}} : abs1;
            rem     <= '0;
            dvs     <= abs2;
            cnt     <= op_word ? CW'(31) : CW'(XLEN-1);
            q_neg   <= s1 ^ s2;
            r_neg   <= s1;
            is_rem  <= op_rem;
            is_word <= op_word;
            if (special) result <= fmt_res(op_rem ? spec_r : spec_q, op_word);
        end else if (state == S_CALC) begin
            quo <= {quo[XLEN-2:0], ~diff[XLEN]};
            rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            cnt <= cnt - CW'(1);
        end else if (state == S_FIX && !flush) begin
            result <= fmt_res(is_rem ? rem_fix : quo_fix, is_word);
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_div_ctrl.sv
// Randomized and directed bench for the divider controller against a plain-arithmetic reference.
module tb_ysyx_22050854_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic [3:0]  div_ctr = 4'h0;
    logic [63:0] src1 = 64'h0;
    logic [63:0] src2 = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22050854_div_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_ctr   (div_ctr),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [3:0] ctr, input logic [63:0] a, input logic [63:0] b);
        logic [31:0]        a32, b32, r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic [63:0]        r;
        a32 = a[31:0];
        b32 = b[31:0];
        sa32 = a32;
        sb32 = b32;
        sa = a;
        sb = b;
        if (ctr[3]) begin
            if (b32 == 32'h0)
                r32 = ctr[1] ? a32 : 32'hFFFF_FFFF;
            else if (!ctr[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = ctr[1] ? 32'h0 : a32;
            else if (ctr[0])
                r32 = ctr[1] ? a32 % b32 : a32 / b32;
            else
                r32 = ctr[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'h0)
                r = ctr[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (!ctr[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
                r = ctr[1] ? 64'h0 : a;
            else if (ctr[0])
                r = ctr[1] ? a % b : a / b;
            else
                r = ctr[1] ? 64'(sa % sb) : 64'(sa / sb);
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] ctr, input logic [63:0] a, input logic [63:0] b);
        logic zero, ovf;
        if (ctr[3]) begin
            zero = (b[31:0] == 32'h0);
            ovf  = !ctr[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        end else begin
            zero = (b == 64'h0);
            ovf  = !ctr[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF;
        end
        if (zero || ovf) return 1;
        return ctr[3] ? 34 : 66;
    endfunction

    task automatic run_op(input logic [3:0] ctr, input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp_r;
        int          exp_lat;
        int          lat;
        exp_r   = ref_div(ctr, a, b);
        exp_lat = ref_lat(ctr, a, b);
        @(negedge clk);
        chk("ready_idle", 64'(div_ready), 64'd1);
        div_valid = 1'b1;
        div_ctr   = ctr;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        div_ctr   = 4'($urandom_range(0, 15));
        src1      = {$urandom(), $urandom()};
        src2      = {$urandom(), $urandom()};
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", result, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", result, exp_r);
            chk("hold_ready", 64'(div_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_after", 64'(div_ready), 64'd1);
    endtask

    task automatic start_only(input logic [3:0] ctr, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        div_valid = 1'b1;
        div_ctr   = ctr;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]  ctr;
        logic [63:0] a, b;
        logic        saw;
        int          mode;

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(div_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        run_op(4'b0101, 64'd100, 64'd7, 0);
        run_op(4'b0111, 64'd100, 64'd7, 0);
        run_op(4'b0100, -64'sd7, 64'd2, 0);
        run_op(4'b0110, -64'sd7, 64'd2, 0);
        run_op(4'b0110, 64'd7, -64'sd2, 0);
        run_op(4'b0101, 64'd5, 64'd0, 0);
        run_op(4'b0111, 64'd5, 64'd0, 0);
        run_op(4'b1110, 64'h8000_0000, 64'd0, 0);
        run_op(4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(4'b1100, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        run_op(4'b1101, 64'hFFFF_FFFF, 64'd1, 0);
        run_op(4'b1100, 64'h1_0000_0006, 64'd3, 0);
        run_op(4'b0101, 64'd1000, 64'd33, 5);

        // flush together with a request: nothing accepted
        @(negedge clk);
        div_valid = 1'b1;
        flush     = 1'b1;
        div_ctr   = 4'b0101;
        src1      = 64'd9;
        src2      = 64'd3;
        @(negedge clk);
        div_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_no_accept", 64'(busy), 64'd0);

        // flush in the middle of CALC
        start_only(4'b0101, 64'd100, 64'd7);
        repeat (10) @(negedge clk);
        chk("calc_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 64'(div_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("flush_never_valid", 64'(saw), 64'd0);

        // flush in DONE while the consumer is ready: result not delivered
        start_only(4'b0101, 64'd5, 64'd0);
        @(negedge clk);
        chk("done_valid", 64'(out_valid), 64'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("done_flush_valid", 64'(out_valid), 64'd0);
        chk("done_flush_ready", 64'(div_ready), 64'd1);

        // reset in the middle of CALC
        start_only(4'b0100, -64'sd12345, 64'd17);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(div_ready), 64'd1);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        run_op(4'b0100, -64'sd12345, 64'd17, 1);

        for (int k = 0; k < 30; k++) begin
            ctr  = 4'($urandom_range(0, 15));
            mode = $urandom_range(0, 5);
            a    = {$urandom(), $urandom()};
            b    = {$urandom(), $urandom()};
            case (mode)
                1: b = 64'($urandom_range(1, 20));
                2: b = $urandom_range(0, 1) ? 64'h0 : {$urandom(), 32'h0};
                3: begin
                    b = 64'hFFFF_FFFF_FFFF_FFFF;
                    a = ctr[3] ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
                end
                4: b = b >> $urandom_range(0, 60);
                5: b = -64'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(ctr, a, b, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
